// File: rtl/nibbler_trace_buffer.sv
// rtl/nibbler_trace_buffer.sv - circular trace capture of Nibbler uP state with pc-match trigger
// Keeps pre-trigger history, stops post_count samples after the trigger and drains oldest-first.
module nibbler_trace_buffer #(
  parameter int PC_W          = 12,
  parameter int PB_W          = 8,
  parameter int DATA_W        = 4,
  parameter int DEPTH         = 16,
  parameter bit CAPTURE_PHASE = 1'b1,
  localparam int ADDR_W       = $clog2(DEPTH),
  localparam int REC_W        = PC_W + PB_W + DATA_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [PC_W-1:0]   trig_pc,
  input  logic [ADDR_W:0]   post_count,
  input  logic              phase,
  input  logic [PC_W-1:0]   pc,
  input  logic [PB_W-1:0]   program_byte,
  input  logic [DATA_W-1:0] accu,
  input  logic              c_flag,
  input  logic              z_flag,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [REC_W-1:0]  rd_data,
  output logic [ADDR_W:0]   fill,
  output logic [1:0]        state,
  output logic              triggered
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURING = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [REC_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_base;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     post_min;
  logic [REC_W-1:0]    record;
  logic                strobe;
  logic                do_write, do_pop, do_clear, set_trig, dec_rem;

  assign record   = {pc, program_byte, accu, c_flag, z_flag};
  assign post_min = (post_count > DEPTH_L) ? DEPTH_L : post_count;
  assign strobe   = (phase == CAPTURE_PHASE) && ((state_q == ARMED) || (state_q == CAPTURING));

  // Oldest entry sits fill slots behind the write pointer; a full buffer wraps onto wr_ptr itself.
  assign rd_base   = wr_ptr - fill[ADDR_W-1:0];
  assign rd_valid  = (state_q == DONE) && (fill != '0);
  assign rd_data   = rd_valid ? mem[rd_base] : '0;
  assign state     = state_q;

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    set_trig = 1'b0;
    dec_rem  = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d  = ARMED;
            do_clear = 1'b1;
          end
        end
        ARMED: begin
          if (strobe) begin
            do_write = 1'b1;
            if (pc == trig_pc) begin
              set_trig = 1'b1;
              state_d  = (post_min == '0) ? DONE : CAPTURING;
            end
          end
        end
        CAPTURING: begin
          if (strobe) begin
            do_write = 1'b1;
            dec_rem  = 1'b1;
            if (remaining == ONE_L) state_d = DONE;
          end
        end
        DONE: begin
          if (arm) begin
            state_d  = ARMED;
            do_clear = 1'b1;
          end else if (rd_valid && rd_ready) begin
            do_pop = 1'b1;
            if (fill == ONE_L) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill      <= '0;
      wr_ptr    <= '0;
      triggered <= 1'b0;
      remaining <= '0;
    end else if (do_clear) begin
      fill      <= '0;
      wr_ptr    <= '0;
      triggered <= 1'b0;
      remaining <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill != DEPTH_L) fill <= fill + ONE_L;
      end else if (do_pop) begin
        fill <= fill - ONE_L;
      end
      if (set_trig) begin
        triggered <= 1'b1;
        remaining <= post_min;
      end else if (dec_rem) begin
        remaining <= remaining - ONE_L;
      end
    end
  end

  // Storage carries no reset; rd_data is masked until a capture completes.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= record;
  end

endmodule

// File: tb/tb_nibbler_trace_buffer.sv
// tb/tb_nibbler_trace_buffer.sv - self-checking bench for nibbler_trace_buffer
// Queue scoreboard of expected records, directed capture/drain/abort/reset scenarios.
module tb_nibbler_trace_buffer;

  localparam int DEPTH = 16;
  localparam int REC_W = 26;

  logic              clk = 1'b0;
  logic              reset, arm, abort, phase, c_flag, z_flag, rd_ready;
  logic [11:0]       trig_pc, pc;
  logic [4:0]        post_count;
  logic [7:0]        program_byte;
  logic [3:0]        accu;
  logic              rd_valid, triggered;
  logic [REC_W-1:0]  rd_data;
  logic [4:0]        fill;
  logic [1:0]        state;

  nibbler_trace_buffer #(
    .PC_W(12), .PB_W(8), .DATA_W(4), .DEPTH(DEPTH), .CAPTURE_PHASE(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_pc(trig_pc),
    .post_count(post_count), .phase(phase), .pc(pc), .program_byte(program_byte),
    .accu(accu), .c_flag(c_flag), .z_flag(z_flag), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .fill(fill), .state(state),
    .triggered(triggered)
  );

  always #5 clk = ~clk;

  int               tests = 0;
  int               failures = 0;
  logic [REC_W-1:0] exp_q[$];
  int               m_state = 0;
  int               m_rem = 0;
  bit               m_trig = 1'b0;
  logic [REC_W-1:0] first_rec, last_rec;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [11:0] p);
    logic [REC_W-1:0] r;
    phase        = 1'b1;
    pc           = p;
    program_byte = 8'($urandom);
    accu         = 4'($urandom);
    {c_flag, z_flag} = 2'($urandom);
    r = {pc, program_byte, accu, c_flag, z_flag};
    if (m_state == 1 || m_state == 2) begin
      exp_q.push_back(r);
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      if (m_state == 1) begin
        if (p == trig_pc) begin
          m_trig  = 1'b1;
          m_rem   = (int'(post_count) > DEPTH) ? DEPTH : int'(post_count);
          m_state = (m_rem == 0) ? 3 : 2;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
    step();
    phase = 1'b0;
  endtask

  // Arm, then feed pc 0,1,2,... on alternating phases until the model reaches DONE.
  task automatic capture(input logic [11:0] tpc, input logic [4:0] post, input int maxn,
                         input bit perturb);
    trig_pc    = tpc;
    post_count = post;
    arm = 1'b1;
    step();
    arm = 1'b0;
    exp_q.delete();
    m_state = 1;
    m_trig  = 1'b0;
    for (int n = 0; n < maxn && m_state != 3; n++) begin
      phase = 1'b0;
      step();
      sample(12'(n));
      if (perturb && m_trig) begin
        trig_pc    = 12'(n + 1);
        post_count = 5'd15;
      end
    end
  endtask

  task automatic drain(output logic [REC_W-1:0] first, output logic [REC_W-1:0] last);
    int n = 0;
    first = '0;
    last  = '0;
    while (exp_q.size() > 0 && n < DEPTH + 1) begin
      check("rd_valid", 64'(rd_valid), 64'd1);
      check("rd_data", 64'(rd_data), 64'(exp_q[0]));
      check("fill_drain", 64'(fill), 64'(exp_q.size()));
      if (n == 0) first = rd_data;
      last = rd_data;
      rd_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
      n++;
    end
    rd_ready = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("state_after_drain", 64'(state), 64'd0);
    check("fill_after_drain", 64'(fill), 64'd0);
    check("rd_data_after_drain", 64'(rd_data), 64'd0);
    m_state = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; phase = 1'b0; rd_ready = 1'b0;
    trig_pc = '0; pc = '0; post_count = '0; program_byte = '0; accu = '0;
    c_flag = 1'b0; z_flag = 1'b0;
    #3;
    check("reset_state", 64'(state), 64'd0);
    check("reset_fill", 64'(fill), 64'd0);
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_data", 64'(rd_data), 64'd0);
    check("reset_trig", 64'(triggered), 64'd0);
    step(); step();
    reset = 1'b0;
    step();

    // 1: basic capture with pre-trigger history; trigger inputs changed after trigger
    capture(12'd5, 5'd3, 40, 1'b1);
    check("t1_state", 64'(state), 64'd3);
    check("t1_fill", 64'(fill), 64'd9);
    check("t1_trig", 64'(triggered), 64'd1);
    drain(first_rec, last_rec);
    check("t1_first_pc", 64'(first_rec[25:14]), 64'd0);
    check("t1_last_pc", 64'(last_rec[25:14]), 64'd8);

    // 2: wrap, oldest entries overwritten
    capture(12'd20, 5'd2, 40, 1'b0);
    check("t2_state", 64'(state), 64'd3);
    check("t2_fill", 64'(fill), 64'd16);
    check("t2_trig", 64'(triggered), 64'd1);
    drain(first_rec, last_rec);
    check("t2_first_pc", 64'(first_rec[25:14]), 64'd7);
    check("t2_last_pc", 64'(last_rec[25:14]), 64'd22);

    // 3: post_count zero stops on the trigger sample
    capture(12'd3, 5'd0, 40, 1'b0);
    check("t3_state", 64'(state), 64'd3);
    check("t3_fill", 64'(fill), 64'd4);
    drain(first_rec, last_rec);
    check("t3_last_pc", 64'(last_rec[25:14]), 64'd3);

    // 4: backpressure holds data and fill
    capture(12'd2, 5'd4, 40, 1'b0);
    check("t4_fill", 64'(fill), 64'd7);
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b0;
      step();
      check("t4_hold_data", 64'(rd_data), 64'(exp_q[0]));
      check("t4_hold_fill", 64'(fill), 64'd7);
      check("t4_hold_state", 64'(state), 64'd3);
    end
    drain(first_rec, last_rec);
    check("t4_last_pc", 64'(last_rec[25:14]), 64'd6);

    // 5: abort and arm together while capturing
    capture(12'd1, 5'd10, 4, 1'b0);
    check("t5_capturing", 64'(state), 64'd2);
    check("t5_trig_before", 64'(triggered), 64'd1);
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    exp_q.delete(); m_state = 0;
    check("t5_state", 64'(state), 64'd0);
    check("t5_fill", 64'(fill), 64'd0);
    check("t5_trig", 64'(triggered), 64'd0);

    // 6: asynchronous reset between edges mid-capture
    capture(12'd0, 5'd10, 3, 1'b0);
    check("t6_capturing", 64'(state), 64'd2);
    check("t6_fill_before", 64'(fill), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("t6_state", 64'(state), 64'd0);
    check("t6_fill", 64'(fill), 64'd0);
    check("t6_trig", 64'(triggered), 64'd0);
    check("t6_valid", 64'(rd_valid), 64'd0);
    check("t6_data", 64'(rd_data), 64'd0);
    #1 reset = 1'b0;
    exp_q.delete(); m_state = 0;
    step();
    check("t6_state_after", 64'(state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
